riscv_muldiv_unit: RTL and testbench
====================================

// Module: riscv_muldiv_unit
// PURPOSE
//   Parametrised iterative multiply/divide unit for the RV32M/RV64M extension.
//   Sits in EX next to the single-cycle ALU. Takes one operation per handshake and
//   runs it over several cycles. Holds the result until the pipeline accepts it.
//   Supports tag passthrough and pipeline flush.
// PARAMETERS
//   XLEN      32  operand/result width; 32 or 64
//   MUL_STEP  1   multiplier bits retired per cycle; 1, 2 or 4; must divide XLEN
//   TAG_W     5   width of opaque tag (e.g. rd index) carried with each op
// PORTS
//   clk         in   1          clock, rising edge
//   rst         in   1          synchronous reset, active-high
//   flush       in   1          kill any in-flight or held op
//   in_valid    in   1          op request valid
//   in_ready    out  1          unit can accept op this cycle
//   in_op       in   mdu_ops_t  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   in_a        in   XLEN       rs1 operand
//   in_b        in   XLEN       rs2 operand
//   in_tag      in   TAG_W      tag, returned unchanged on out_tag
//   out_valid   out  1          result valid; held until out_ready
//   out_ready   in   1          consumer accepts result
//   out_result  out  XLEN       result
//   out_tag     out  TAG_W      tag of the op being returned
//   busy        out  1          high in every state except IDLE
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-high (rst).
//   - Reset values: state=IDLE; out_valid, out_result, out_tag, busy all 0.
//     in_ready is 0 while rst is high.
//   - Accept: the op is taken when in_valid & in_ready at a rising edge.
//     in_ready = !rst & !flush & (IDLE | (DONE & out_ready)).
//     The DONE path allows back-to-back ops with no bubble.
//   - Release: the result retires when out_valid & out_ready at an edge.
//     out_result and out_tag stay stable while out_valid=1 and out_ready=0.
//   - FSM states: IDLE -> MUL | DIV | DONE; MUL -> FIX; DIV -> FIX; FIX -> DONE;
//     DONE -> IDLE on retire, or -> MUL/DIV on retire plus a new accept.
//   - Operand capture: signed ops store |a| and |b| plus the sign of the result.
//     MULHSU treats a as signed and b as unsigned. MULHU, DIVU and REMU are unsigned.
//   - MUL state: shift-add over a 2*XLEN product register, MUL_STEP bits per cycle.
//     Runs for XLEN/MUL_STEP cycles.
//   - DIV state: restoring radix-2 divider, one quotient bit per cycle, XLEN cycles.
//   - FIX state: conditionally negates the product or quotient/remainder, then
//     selects the result.
//     MUL returns the low half. The MULH* ops return the high half.
//     The remainder takes the sign of the dividend.
//   - Latency (accept edge to first cycle with out_valid=1):
//       MUL*         XLEN/MUL_STEP + 2   (34 for the 32/1 configuration)
//       DIV*/REM*    XLEN + 2            (34 for XLEN=32)
//   - Special cases resolve in the capture cycle (IDLE -> DONE), latency 1:
//       divide by zero:    DIV/DIVU = all ones; REM/REMU = a
//       signed overflow:   a = most-negative and b = -1 -> DIV = a; REM = 0
//   - Flush: at the next edge the state goes to IDLE and out_valid=0; the op is lost.
//     If flush and in_valid are high together, nothing is accepted.
//     If flush and the retire handshake are high together, flush wins; the
//     consumer must also ignore that result.
//   - Reset mid-operation behaves like flush and also clears out_result and out_tag.
//   - The iteration counter is $clog2(XLEN)+1 bits wide and never wraps inside an op.
//   - All arithmetic is 2*XLEN bits wide internally. No X may propagate to
//     out_result while out_valid=1.
// STRUCTURE
//   - my_pkg: typedef enum mdu_ops_t for the 8 ops; typedef enum mdu_state_t
//     {IDLE, MUL, DIV, FIX, DONE}; localparam MDU_MAX_XLEN=64.
//   - Sub-module riscv_div_step: combinational single restoring step
//     (remainder, divisor, dividend bit) -> (new remainder, quotient bit).
//     Instantiated once.
//   - The multiplier step is inline. It uses MUL_STEP partial products per cycle.
// TESTING
//   1) MUL 7 x 0xFFFFFFFD (-3) -> out_result 0xFFFFFFEB, out_tag echoed.
//      out_valid rises 34 cycles after accept.
//   2) MULH 0x80000000 x 0x80000000 -> 0x40000000.
//      MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//      MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//   3) DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
//      DIVU 100 / 7 -> 14; REMU -> 2.
//   4) Special cases, each with out_valid one cycle after accept:
//      DIVU 0x1234 / 0 -> 0xFFFFFFFF; REM 0x1234 / 0 -> 0x1234;
//      DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
//   5) Backpressure and back-to-back:
//      hold out_ready=0 for 10 cycles after out_valid -> result/tag stable, in_ready=0.
//      Then out_ready=1 with a second in_valid -> both handshakes in the same cycle.
//   6) Flush at iteration 5 of a DIV -> state IDLE next cycle, out_valid never rises.
//      A new MUL issued the following cycle returns the correct result.
//      Repeat with rst instead of flush and check all outputs are 0.

Source files
------------

// File: rtl/riscv_muldiv_unit_pkg.sv
// Shared types for the iterative RV32M/RV64M multiply/divide unit.
package riscv_muldiv_unit_pkg;

  localparam int MDU_MAX_XLEN = 64;

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } mdu_ops_t;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
  } mdu_state_t;

endpackage

// File: rtl/riscv_muldiv_unit_div_step.sv
// One restoring division step: shift in a dividend bit, subtract if it fits.
module riscv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] div_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);
  logic [XLEN:0] sh;

  // rem_i < div_i always holds, so the restored remainder fits in XLEN bits
  always_comb begin
    sh    = {rem_i, bit_i};
    q_o   = (sh >= {1'b0, div_i});
    rem_o = q_o ? XLEN'(sh - {1'b0, div_i}) : sh[XLEN-1:0];
  end
endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: magnitude datapath, sign fix-up, held result.
module riscv_muldiv_unit
  import riscv_muldiv_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  mdu_ops_t         in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam int PW = 2 * XLEN;
  localparam logic [CW-1:0] MUL_ITER = CW'(XLEN / MUL_STEP);
  localparam logic [CW-1:0] DIV_ITER = CW'(XLEN);

  mdu_state_t       state_q, state_d;
  mdu_ops_t         op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  res_q, res_d, opnd_q, opnd_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d, negr_q, negr_d;

  logic             accept, a_sgn, b_sgn, is_div, div0, ovf;
  logic [XLEN-1:0]  abs_a, abs_b, drem, qv, rv;
  logic             dq;
  logic [XLEN+MUL_STEP-1:0] mul_acc;
  logic [PW-1:0]    mul_next, div_next, full;

  assign in_ready   = !rst && !flush &&
                      (state_q == S_IDLE || (state_q == S_DONE && out_ready));
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_result = res_q;
  assign out_tag    = tag_q;

  // MUL's low half is sign-agnostic, so it shares the signed capture path
  assign a_sgn  = in_a[XLEN-1] && (in_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign b_sgn  = in_b[XLEN-1] && (in_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  assign abs_a  = a_sgn ? -in_a : in_a;
  assign abs_b  = b_sgn ? -in_b : in_b;
  assign is_div = in_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign div0   = is_div && (in_b == '0);
  assign ovf    = (in_op inside {OP_DIV, OP_REM}) &&
                  (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);

  // prod_q = {partial high, multiplier}; MUL_STEP bits retire per cycle
  always_comb begin
    mul_acc = {{MUL_STEP{1'b0}}, prod_q[PW-1:XLEN]};
    for (int k = 0; k < MUL_STEP; k++)
      if (prod_q[k]) mul_acc = mul_acc + ({{MUL_STEP{1'b0}}, opnd_q} << k);
    mul_next = {mul_acc, prod_q[XLEN-1:MUL_STEP]};
  end

  // prod_q = {remainder, dividend shifting out / quotient shifting in}
  riscv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i (prod_q[PW-1:XLEN]),
    .div_i (opnd_q),
    .bit_i (prod_q[XLEN-1]),
    .rem_o (drem),
    .q_o   (dq)
  );
  assign div_next = {drem, prod_q[XLEN-2:0], dq};

  assign full = negq_q ? -prod_q : prod_q;
  assign qv   = negq_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
  assign rv   = negr_q ? -prod_q[PW-1:XLEN] : prod_q[PW-1:XLEN];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    res_d   = res_q;
    opnd_d  = opnd_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      S_MUL, S_DIV: begin
        prod_d = (state_q == S_MUL) ? mul_next : div_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        case (op_q)
          OP_MUL:                       res_d = full[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: res_d = full[PW-1:XLEN];
          OP_DIV, OP_DIVU:              res_d = qv;
          default:                      res_d = rv;
        endcase
        state_d = S_DONE;
      end
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: ;
    endcase
    if (accept) begin
      op_d   = in_op;
      tag_d  = in_tag;
      negq_d = a_sgn ^ b_sgn;
      negr_d = a_sgn;
      opnd_d = is_div ? abs_b : abs_a;
      prod_d = {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
      cnt_d  = is_div ? DIV_ITER : MUL_ITER;
      if (div0) begin
        res_d   = (in_op inside {OP_DIV, OP_DIVU}) ? '1 : in_a;
        state_d = S_DONE;
      end else if (ovf) begin
        res_d   = (in_op == OP_DIV) ? in_a : '0;
        state_d = S_DONE;
      end else begin
        state_d = is_div ? S_DIV : S_MUL;
      end
    end
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      tag_q   <= '0;
      res_q   <= '0;
      opnd_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      opnd_q  <= opnd_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed + random scoreboard bench for riscv_muldiv_unit (XLEN=32, MUL_STEP=1).
module tb_riscv_muldiv_unit;
  import riscv_muldiv_unit_pkg::*;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  mdu_ops_t    in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  riscv_muldiv_unit #(.XLEN(32), .MUL_STEP(1), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  typedef struct { logic [31:0] res; logic [4:0] tag; int lat; } exp_t;
  exp_t q[$];
  int ncmp = 0, nerr = 0, cyc = 0, acc_cyc = 0;
  logic [31:0] last_res;
  logic [4:0]  last_tag;

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input mdu_ops_t op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    logic ov;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      OP_DIV:    begin if (b == 0) return '1; if (ov) return a; p = sa / sb; return p[31:0]; end
      OP_REM:    begin if (b == 0) return a; if (ov) return 0; p = sa % sb; return p[31:0]; end
      OP_DIVU:   return (b == 0) ? '1 : a / b;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input mdu_ops_t op, input logic [31:0] a, input logic [31:0] b);
    if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
      if (b == 0) return 1;
      if ((op inside {OP_DIV, OP_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    end
    return 34;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic drive(input mdu_ops_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit push);
    exp_t e;
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1;
    if (push) begin
      e.res = model(op, a, b); e.tag = tag; e.lat = lat_of(op, a, b);
      q.push_back(e);
    end
    #1 chk("in_ready_at_accept", in_ready, 1);
    acc_cyc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_out();
    int n = 0;
    exp_t e;
    while (out_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (out_valid !== 1'b1) begin
      chk("out_valid_timeout", out_valid, 1);
      void'(q.pop_front());
    end else begin
      e = q.pop_front();
      chk("result", out_result, e.res);
      chk("tag", out_tag, e.tag);
      chk("latency", 64'(cyc - acc_cyc + 1), 64'(e.lat));
      last_res = e.res; last_tag = e.tag;
    end
  endtask

  task automatic run(input mdu_ops_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    drive(op, a, b, tag, 1);
    wait_out();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 1;
    in_op = OP_MUL; in_a = 0; in_b = 0; in_tag = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    @(negedge clk);

    run(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd3);
    chk("mul_spec_value", last_res, 32'hFFFF_FFEB);
    run(OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd4);
    run(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5);
    run(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6);
    chk("mulhu_spec_value", last_res, 32'hFFFF_FFFE);
    run(OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd7);
    run(OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd8);
    run(OP_DIVU,   32'd100,        32'd7,         5'd9);
    run(OP_REMU,   32'd100,        32'd7,         5'd10);
    run(OP_DIVU,   32'h1234,       32'd0,         5'd11);
    run(OP_REM,    32'h1234,       32'd0,         5'd12);
    run(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13);
    run(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14);
    for (int i = 0; i < 6; i++)
      run(mdu_ops_t'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 9)) : $urandom, 5'(i + 16));

    // Backpressure, then retire and accept on the same edge
    out_ready = 0;
    drive(OP_DIV, 32'hFFFF_FF00, 32'd5, 5'd21, 1);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", out_result, last_res);
      chk("hold_tag", out_tag, last_tag);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    #1 chk("b2b_retire_valid", out_valid, 1);
    drive(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd22, 1);
    chk("b2b_busy", busy, 1);
    wait_out();
    @(negedge clk);

    // Flush at iteration 5 of a DIV
    drive(OP_DIV, 32'd1000, 32'd3, 5'd23, 0);
    repeat (4) @(negedge clk);
    chk("pre_flush_busy", busy, 1);
    flush = 1;
    #1 chk("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);
    run(OP_MUL, 32'd12345, 32'd678, 5'd24);

    // Reset mid-operation
    drive(OP_REMU, 32'd99999, 32'd7, 5'd25, 0);
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_result", out_result, 0);
    chk("mrst_tag", out_tag, 0);
    chk("mrst_busy", busy, 0);
    rst = 0;
    run(OP_MUL, 32'hFFFF_FFFF, 32'd9, 5'd26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
